// File: rtl/counter_bank.sv
// counter_bank: a bank of independent up/down counters with a shared counting
// mode, per-channel compare-hit pulses and a snapshot streamer. The streamer
// captures all counts atomically and presents them one word per channel over a
// valid/ready handshake.
module counter_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 4,
  parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         clock,
  input  logic                         i_reset,
  input  logic [NUM_CH-1:0]            i_en,
  input  logic [NUM_CH-1:0]            i_dir,
  input  logic [NUM_CH-1:0]            i_clr,
  input  logic [NUM_CH-1:0]            i_load,
  input  logic [NUM_CH*DATA_WIDTH-1:0] i_load_data,
  input  logic [NUM_CH*DATA_WIDTH-1:0] i_cmp_data,
  input  logic [1:0]                   i_mode,
  output logic [NUM_CH*DATA_WIDTH-1:0] o_count,
  output logic [NUM_CH-1:0]            o_hit,
  input  logic                         i_snap_req,
  output logic [DATA_WIDTH-1:0]        o_snap_data,
  output logic [CH_W-1:0]              o_snap_ch,
  output logic                         o_snap_valid,
  output logic                         o_snap_last,
  input  logic                         i_snap_ready,
  output logic                         o_busy
);

  typedef logic [DATA_WIDTH-1:0] word_t;
  typedef enum logic {IDLE, SEND} snap_state_t;

  localparam word_t           ALL_ONES = '1;
  localparam word_t           ONE      = word_t'(1);
  localparam logic [CH_W-1:0] LAST_CH  = CH_W'(NUM_CH - 1);

  // One enabled count step under the given mode. Wrap is the fallback; the
  // other modes only differ at their boundary values.
  function automatic word_t count_step(input word_t cur, input word_t cmp,
                                       input logic up, input logic [1:0] mode);
    word_t inc;
    word_t dec;
    word_t nxt;
    inc = cur + ONE;
    dec = cur - ONE;
    case (mode)
      2'b01:   nxt = up ? ((cur == ALL_ONES) ? cur : inc) : ((cur == '0) ? cur : dec);
      2'b10:   nxt = up ? ((cur == cmp) ? '0 : inc)       : ((cur == '0) ? cmp : dec);
      2'b11:   nxt = up ? ((cur == cmp) ? cur : inc)      : ((cur == '0) ? cur : dec);
      default: nxt = up ? inc : dec;
    endcase
    return nxt;
  endfunction

  word_t           cnt_q [NUM_CH];
  word_t           cnt_d [NUM_CH];
  word_t           cap_q [NUM_CH];
  logic [NUM_CH-1:0] hit_d;

  snap_state_t     state_q, state_d;
  logic [CH_W-1:0] ch_q, ch_d;
  logic            capture;

  // Per-channel next count: clear beats load beats enable beats hold. A hit
  // is flagged only for a real enabled step that lands on the compare value;
  // a mode-limited hold at the boundary does not pulse again.
  always_comb begin
    word_t step_v;
    word_t cmp_v;
    step_v = '0;
    cmp_v  = '0;
    hit_d  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      cmp_v    = i_cmp_data[k*DATA_WIDTH +: DATA_WIDTH];
      step_v   = count_step(cnt_q[k], cmp_v, i_dir[k], i_mode);
      cnt_d[k] = cnt_q[k];
      if (i_clr[k]) begin
        cnt_d[k] = '0;
      end else if (i_load[k]) begin
        cnt_d[k] = i_load_data[k*DATA_WIDTH +: DATA_WIDTH];
      end else if (i_en[k]) begin
        cnt_d[k] = step_v;
        hit_d[k] = (step_v == cmp_v) && (step_v != cnt_q[k]);
      end
    end
  end

  // Counter and hit registers.
  always_ff @(posedge clock) begin
    if (!i_reset) begin
      for (int k = 0; k < NUM_CH; k++) cnt_q[k] <= '0;
      o_hit <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) cnt_q[k] <= cnt_d[k];
      o_hit <= hit_d;
    end
  end

  // Flatten the counter array onto the packed output bus.
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) o_count[k*DATA_WIDTH +: DATA_WIDTH] = cnt_q[k];
  end

  // Snapshot FSM: next state, channel pointer and handshake outputs.
  always_comb begin
    state_d      = state_q;
    ch_d         = ch_q;
    capture      = 1'b0;
    o_snap_valid = 1'b0;
    o_snap_last  = 1'b0;
    o_snap_data  = '0;
    o_busy       = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_snap_req) begin
          capture = 1'b1;
          state_d = SEND;
          ch_d    = '0;
        end
      end
      SEND: begin
        o_busy       = 1'b1;
        o_snap_valid = 1'b1;
        o_snap_last  = (ch_q == LAST_CH);
        o_snap_data  = cap_q[ch_q];
        if (i_snap_ready) begin
          if (ch_q == LAST_CH) begin
            state_d = IDLE;
            ch_d    = '0;
          end else begin
            ch_d = ch_q + CH_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_snap_ch = ch_q;

  // Snapshot FSM state register.
  always_ff @(posedge clock) begin
    if (!i_reset) begin
      state_q <= IDLE;
      ch_q    <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
    end
  end

  // Capture buffer: takes the pre-edge counts of every channel in one cycle.
  always_ff @(posedge clock) begin
    if (!i_reset) begin
      for (int k = 0; k < NUM_CH; k++) cap_q[k] <= '0;
    end else if (capture) begin
      for (int k = 0; k < NUM_CH; k++) cap_q[k] <= cnt_q[k];
    end
  end

endmodule

// File: tb/tb_counter_bank.sv
// Directed bench for counter_bank at DATA_WIDTH=8, NUM_CH=4.
module tb_counter_bank;

  localparam int DW = 8;
  localparam int NC = 4;
  localparam int CW = 2;

  logic            clock = 1'b0;
  logic            i_reset;
  logic [NC-1:0]   i_en, i_dir, i_clr, i_load;
  logic [NC*DW-1:0] i_load_data, i_cmp_data;
  logic [1:0]      i_mode;
  logic [NC*DW-1:0] o_count;
  logic [NC-1:0]   o_hit;
  logic            i_snap_req;
  logic [DW-1:0]   o_snap_data;
  logic [CW-1:0]   o_snap_ch;
  logic            o_snap_valid, o_snap_last;
  logic            i_snap_ready;
  logic            o_busy;

  int n_checks = 0;
  int n_fail   = 0;

  counter_bank #(.DATA_WIDTH(DW), .NUM_CH(NC)) dut (
    .clock(clock), .i_reset(i_reset), .i_en(i_en), .i_dir(i_dir), .i_clr(i_clr),
    .i_load(i_load), .i_load_data(i_load_data), .i_cmp_data(i_cmp_data),
    .i_mode(i_mode), .o_count(o_count), .o_hit(o_hit), .i_snap_req(i_snap_req),
    .o_snap_data(o_snap_data), .o_snap_ch(o_snap_ch), .o_snap_valid(o_snap_valid),
    .o_snap_last(o_snap_last), .i_snap_ready(i_snap_ready), .o_busy(o_busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [DW-1:0] cnt(input int k);
    return o_count[k*DW +: DW];
  endfunction

  task automatic set_ld(input int k, input logic [DW-1:0] v);
    i_load_data[k*DW +: DW] = v;
  endtask

  task automatic set_cmp(input int k, input logic [DW-1:0] v);
    i_cmp_data[k*DW +: DW] = v;
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_cnt"},   o_count, '0);
    check({tag, "_hit"},   o_hit, '0);
    check({tag, "_busy"},  o_busy, 0);
    check({tag, "_valid"}, o_snap_valid, 0);
    check({tag, "_last"},  o_snap_last, 0);
    check({tag, "_ch"},    o_snap_ch, 0);
    check({tag, "_data"},  o_snap_data, 0);
  endtask

  initial begin
    logic [DW-1:0] exp_ar [8];
    logic [DW-1:0] snap_exp [4];
    exp_ar   = '{8'd1, 8'd2, 8'd3, 8'd0, 8'd1, 8'd2, 8'd3, 8'd0};
    snap_exp = '{8'h10, 8'h20, 8'h30, 8'h40};

    i_reset = 1'b0; i_en = '0; i_dir = '0; i_clr = '0; i_load = '0;
    i_load_data = '0; i_cmp_data = '0; i_mode = 2'b00;
    i_snap_req = 1'b0; i_snap_ready = 1'b0;
    #1;
    tick(); tick();
    check_idle_zero("reset");
    i_reset = 1'b1;

    // Wrap mode on ch0 (cmp0 = 0)
    set_ld(0, 8'hFE); i_load = 4'b0001; tick();
    check("wrap_load", cnt(0), 8'hFE);
    i_load = '0; i_en = 4'b0001; i_dir = 4'b0001;
    tick(); check("wrap_up1", cnt(0), 8'hFF); check("wrap_hit_ff", o_hit[0], 0);
    tick(); check("wrap_up2", cnt(0), 8'h00); check("wrap_hit_00", o_hit[0], 1);
    tick(); check("wrap_up3", cnt(0), 8'h01); check("wrap_hit_01", o_hit[0], 0);
    i_dir = 4'b0000;
    tick(); check("wrap_dn1", cnt(0), 8'h00);
    tick(); check("wrap_dn2", cnt(0), 8'hFF);
    i_en = '0;

    // Saturate mode on ch1
    i_mode = 2'b01;
    set_ld(1, 8'hFD); i_load = 4'b0010; tick();
    i_load = '0; i_en = 4'b0010; i_dir = 4'b0010;
    tick(); check("sat_up1", cnt(1), 8'hFE);
    tick(); check("sat_up2", cnt(1), 8'hFF);
    for (int i = 0; i < 3; i++) begin tick(); check("sat_up_hold", cnt(1), 8'hFF); end
    i_en = '0; set_ld(1, 8'h01); i_load = 4'b0010; tick();
    i_load = '0; i_en = 4'b0010; i_dir = 4'b0000;
    for (int i = 0; i < 3; i++) begin tick(); check("sat_dn", cnt(1), 8'h00); end
    i_en = '0;

    // Auto-reload on ch2 with cmp 3
    i_mode = 2'b10; set_cmp(2, 8'd3);
    i_clr = 4'b0100; tick(); i_clr = '0;
    check("ar_clr", cnt(2), 8'd0);
    i_en = 4'b0100; i_dir = 4'b0100;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("ar_cnt", cnt(2), exp_ar[i]);
      check("ar_hit", o_hit[2], (exp_ar[i] == 8'd3));
    end
    i_en = '0;

    // Priority on ch3 (cmp3 = 0, so a clear to 0 would look like a hit)
    i_mode = 2'b00; set_ld(3, 8'h55);
    i_clr = 4'b1000; i_load = 4'b1000; i_en = 4'b1000; i_dir = 4'b1000;
    tick(); check("prio_clr", cnt(3), 8'h00); check("prio_clr_hit", o_hit[3], 0);
    i_clr = '0;
    tick(); check("prio_load", cnt(3), 8'h55); check("prio_load_hit", o_hit[3], 0);
    i_load = '0; i_en = '0;

    // Snapshot with stall and a request during busy
    set_cmp(2, 8'h00);
    set_ld(0, 8'h10); set_ld(1, 8'h20); set_ld(2, 8'h30); set_ld(3, 8'h40);
    i_load = 4'b1111; tick(); i_load = '0;
    i_en = 4'b1111; i_dir = 4'b1111; i_snap_req = 1'b1;
    tick(); i_snap_req = 1'b0;
    check("snap_busy", o_busy, 1);
    check("snap_w0_valid", o_snap_valid, 1);
    check("snap_w0_data", o_snap_data, 8'h10);
    check("snap_w0_ch", o_snap_ch, 0);
    check("snap_w0_last", o_snap_last, 0);
    i_snap_ready = 1'b1; tick();
    check("snap_w1_data", o_snap_data, 8'h20); check("snap_w1_ch", o_snap_ch, 1);
    i_snap_ready = 1'b0; tick();
    check("snap_stall_data", o_snap_data, 8'h20); check("snap_stall_ch", o_snap_ch, 1);
    check("snap_stall_valid", o_snap_valid, 1);
    i_snap_ready = 1'b1; i_snap_req = 1'b1; tick();
    check("snap_w2_data", o_snap_data, 8'h30); check("snap_w2_ch", o_snap_ch, 2);
    tick();
    check("snap_w3_data", o_snap_data, 8'h40); check("snap_w3_ch", o_snap_ch, 3);
    check("snap_w3_last", o_snap_last, 1);
    tick();
    i_snap_req = 1'b0;
    check("snap_done_valid", o_snap_valid, 0);
    check("snap_done_busy", o_busy, 0);
    check("snap_count_ran", cnt(0), 8'h16);
    i_en = '0;
    for (int i = 0; i < 3; i++) begin tick(); check("snap_no_second", o_snap_valid, 0); end
    i_snap_ready = 1'b0;

    // One-shot ch3 to cmp, then reset in the middle of a burst
    i_mode = 2'b11; set_cmp(3, 8'h42); set_ld(3, 8'h40);
    i_load = 4'b1000; tick(); i_load = '0;
    i_en = 4'b1000; i_dir = 4'b1000;
    tick(); check("os_up1", cnt(3), 8'h41);
    tick(); check("os_up2", cnt(3), 8'h42); check("os_hit", o_hit[3], 1);
    tick(); check("os_hold", cnt(3), 8'h42); check("os_hold_hit", o_hit[3], 0);
    i_snap_req = 1'b1; tick(); i_snap_req = 1'b0;
    check("rst_w0_data", o_snap_data, 8'h16);
    i_snap_ready = 1'b1; tick();
    check("rst_w1_ch", o_snap_ch, 1);
    i_reset = 1'b0; tick();
    check_idle_zero("midrst");
    i_reset = 1'b1; i_en = '0; tick();
    check("post_rst_valid", o_snap_valid, 0);
    check("post_rst_cnt3", cnt(3), 8'h00);
    i_snap_req = 1'b1; tick(); i_snap_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("zero_cap_valid", o_snap_valid, 1);
      check("zero_cap_ch", o_snap_ch, i);
      check("zero_cap_data", o_snap_data, 0);
      check("zero_cap_last", o_snap_last, (i == 3));
      tick();
    end
    check("zero_cap_end", o_busy, 0);
    if (snap_exp[0] != 8'h10) n_fail++;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
